hilo_muldiv_unit: RTL and testbench
===================================

// Module: hilo_muldiv_unit
// PURPOSE
//  Iterative MIPS-I multiply/divide unit owning the HI/LO registers.
//  Sits downstream of the register file in the EX stage. It consumes the rs/rt read data
//  and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
//  Drives busy so the hazard logic stalls any MFHI/MFLO or new mul/div until completion.
// PARAMETERS
//  XLEN     32  operand width; HI/LO are XLEN each
//  CNT_W    5   iteration counter width, = clog2(XLEN)
// PORTS
//  clk      input   1     rising-edge clock
//  rst      input   1     asynchronous, active-low reset (0 = reset)
//  start    input   1     issue pulse; sampled only when busy=0
//  op       input   3     000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others = no-op
//  rs_data  input   XLEN  operand A (dividend / multiplicand / MTxx source)
//  rt_data  input   XLEN  operand B (divisor / multiplier)
//  flush    input   1     abort in-flight mul/div; HI/LO keep their pre-issue values
//  busy     output  1     mul/div in progress
//  done     output  1     one-cycle pulse in the cycle HI/LO take a mul/div result
//  hi       output  XLEN  HI register (MFHI source)
//  lo       output  XLEN  LO register (MFLO source)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
//  FSM has three states: IDLE, RUN and FIX.
//   IDLE + start + op in {MULT..DIVU}: latch operand magnitudes and result signs, counter=0, go to RUN.
//   RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle, counter++.
//        After XLEN steps, go to FIX.
//   FIX: apply sign correction, write HI/LO, done=1, go to IDLE.
//  Latency: start sampled at edge k; busy=1 after k; hi/lo valid with done=1 after edge k+XLEN+1.
//  busy falls in the same cycle done=1. The next start is accepted on that cycle's edge.
//  MTHI/MTLO: when start is sampled in IDLE, hi (or lo) <= rs_data at that edge. busy stays 0, no done.
//  start while busy=1 is ignored; the stall logic guarantees it does not happen, and the bench asserts it.
//  Undefined op codes: no state change.
//  Arithmetic:
//   MULT/MULTU: {hi,lo} = 2*XLEN-bit product (signed/unsigned).
//   DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
//   DIVU: unsigned quotient/remainder.
//   DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
//   Divide by zero (DIV or DIVU): lo=0xFFFFFFFF, hi=rs_data. This is deterministic; MIPS leaves it undefined.
//  flush in RUN or FIX: return to IDLE next edge, busy=0, done=0, hi/lo unchanged.
//   flush wins over FIX completion in the same cycle.
//   flush with start in IDLE: flush wins, and the op is dropped (including MTxx).
//  Async reset mid-operation: immediate return to reset values; the result is discarded.
//  Outputs hi/lo are registers, never combinational from operands; hi/lo only change at FIX or MTxx.
// STRUCTURE
//  Shared package mips_pkg holds:
//   op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
//   XLEN
//   FSM state constants S_IDLE, S_RUN, S_FIX
//  Natural sub-module: muldiv_datapath.
//   It holds the accumulator/remainder register, the operand shift registers and the single add/sub.
//   Its controls are init, step and is_div.
//  Top level keeps the FSM, counter, sign bookkeeping, FIX negation and the HI/LO registers.
// TESTING
//  MULT  rs=0xFFFFFFFF, rt=0x00000002 -> after 33 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFE.
//  MULTU rs=0xFFFFFFFF, rt=0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE; busy high for exactly 33 cycles.
//  DIV:
//   rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//   rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
//  DIVU rs=0x12345678, rt=0 -> lo=0xFFFFFFFF, hi=0x12345678. Then MTLO rs=0xA5A5A5A5 -> lo=0xA5A5A5A5 next edge, busy=0.
//  Abort and reset:
//   MULT with hi/lo=0x1/0x2 preloaded, flush on cycle 10 -> busy=0 next edge, no done, hi=0x1, lo=0x2.
//   Repeat with rst=0 on cycle 10 -> hi=lo=0 immediately.
//  Back-to-back: issue a new DIVU on the done cycle -> accepted, second done exactly 33 cycles later.
//   Random signed/unsigned pairs are checked against a reference model.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   XLEN / CNT_W : operand width and iteration counter width
//   md_op_e      : op encodings driven on op_i
//   md_state_e   : sequencing FSM states
package mips_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative unsigned multiply / restoring divide datapath.
// Operates on magnitudes only; sign handling lives in the parent.
//   clk_i, rst_ni : clock, async active-low reset
//   init_i        : load operands (a_i, b_i) and clear the accumulator
//   step_i        : perform one shift-add (mul) or shift-subtract (div) step
//   is_div_i      : selects divide behaviour for init and step
//   a_i           : multiplicand / dividend magnitude
//   b_i           : multiplier / divisor magnitude
//   hi_o, lo_o    : product {hi,lo}, or remainder (hi) / quotient (lo)
module muldiv_datapath
  import mips_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            init_i,
  input  logic            step_i,
  input  logic            is_div_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  // acc: product upper half / partial remainder
  // lo : multiplier shifting out + product lower half / dividend shifting out + quotient
  // m  : multiplicand / divisor
  logic [XLEN-1:0] acc_q, acc_d, lo_q, lo_d, m_q, m_d;
  logic [XLEN:0]   addsub_a, addsub_res, mul_sum;

  always_comb begin
    // Divide shifts the next dividend bit into the remainder before subtracting.
    addsub_a   = is_div_i ? {acc_q, lo_q[XLEN-1]} : {1'b0, acc_q};
    addsub_res = is_div_i ? (addsub_a - {1'b0, m_q}) : (addsub_a + {1'b0, m_q});
    mul_sum    = lo_q[0] ? addsub_res : addsub_a;

    acc_d = acc_q;
    lo_d  = lo_q;
    m_d   = m_q;

    if (init_i) begin
      acc_d = '0;
      lo_d  = is_div_i ? a_i : b_i;
      m_d   = is_div_i ? b_i : a_i;
    end else if (step_i) begin
      if (is_div_i) begin
        // Top bit of the difference is the borrow: set means restore.
        if (!addsub_res[XLEN]) begin
          acc_d = addsub_res[XLEN-1:0];
          lo_d  = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d = addsub_a[XLEN-1:0];
          lo_d  = {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        acc_d = mul_sum[XLEN:1];
        lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      lo_q  <= '0;
      m_q   <= '0;
    end else begin
      acc_q <= acc_d;
      lo_q  <= lo_d;
      m_q   <= m_d;
    end
  end

  assign hi_o = acc_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// MIPS-I multiply/divide unit owning the HI/LO registers.
//   clk_i, rst_ni          : clock, async active-low reset
//   start_i, op_i          : issue pulse and op (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   rs_data_i, rt_data_i   : operands
//   flush_i                : abort in-flight op, HI/LO untouched
//   busy_o                 : mul/div in progress
//   done_o                 : one-cycle pulse as HI/LO take a mul/div result
//   hi_o, lo_o             : HI/LO registers
//
// state  | meaning
// S_IDLE | waiting for start; MTHI/MTLO complete here
// S_RUN  | XLEN iterative datapath steps
// S_FIX  | sign correction and HI/LO write
module hilo_muldiv_unit
  import mips_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs_data_i,
  input  logic [XLEN-1:0] rt_data_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic             is_div_q, neg_q, neg_rem_q, div0_q;

  logic             is_md_op, op_signed, sign_a, sign_b, latch;
  logic             dp_init, dp_step, dp_is_div;
  logic [XLEN-1:0]  mag_a, mag_b, dp_hi, dp_lo;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]  quo_fix, rem_fix, res_hi, res_lo;

  assign is_md_op  = (op_i == MD_MULT) || (op_i == MD_MULTU) ||
                     (op_i == MD_DIV)  || (op_i == MD_DIVU);
  assign op_signed = (op_i == MD_MULT) || (op_i == MD_DIV);
  assign sign_a    = op_signed & rs_data_i[XLEN-1];
  assign sign_b    = op_signed & rt_data_i[XLEN-1];
  assign mag_a     = sign_a ? (-rs_data_i) : rs_data_i;
  assign mag_b     = sign_b ? (-rt_data_i) : rt_data_i;
  // Datapath needs the incoming op's kind at init, the latched kind while running.
  assign dp_is_div = (state_q == S_IDLE) ? op_i[1] : is_div_q;

  muldiv_datapath u_dp (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .init_i   (dp_init),
    .step_i   (dp_step),
    .is_div_i (dp_is_div),
    .a_i      (mag_a),
    .b_i      (mag_b),
    .hi_o     (dp_hi),
    .lo_o     (dp_lo)
  );

  // Remainder takes the dividend's sign. For divide-by-zero the datapath
  // remainder equals |rs|, so re-applying that sign reproduces rs exactly.
  always_comb begin
    prod_fix = neg_q ? (-{dp_hi, dp_lo}) : {dp_hi, dp_lo};
    quo_fix  = neg_q ? (-dp_lo) : dp_lo;
    rem_fix  = neg_rem_q ? (-dp_hi) : dp_hi;
    if (is_div_q) begin
      res_hi = rem_fix;
      res_lo = div0_q ? '1 : quo_fix;
    end else begin
      res_hi = prod_fix[2*XLEN-1:XLEN];
      res_lo = prod_fix[XLEN-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dp_init = 1'b0;
    dp_step = 1'b0;
    latch   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          if (is_md_op) begin
            latch   = 1'b1;
            dp_init = 1'b1;
            cnt_d   = '0;
            state_d = S_RUN;
          end else if (op_i == MD_MTHI) begin
            hi_d = rs_data_i;
          end else if (op_i == MD_MTLO) begin
            lo_d = rs_data_i;
          end
        end
      end
      S_RUN: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          dp_step = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush_i) begin
          hi_d   = res_hi;
          lo_d   = res_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      if (latch) begin
        is_div_q  <= op_i[1];
        neg_q     <= sign_a ^ sign_b;
        neg_rem_q <= sign_a;
        div0_q    <= op_i[1] && (rt_data_i == '0);
      end
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs = '0, rt = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  hilo_muldiv_unit dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .op_i      (op),
    .rs_data_i (rs),
    .rt_data_i (rt),
    .flush_i   (flush),
    .busy_o    (busy),
    .done_o    (done),
    .hi_o      (hi),
    .lo_o      (lo)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       nm;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, eh, el;
    string       nm;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done=1 with nothing pending, hi=%h lo=%h", hi, lo);
      end else begin
        e = sb_q.pop_front();
        chk({e.nm, "_hi"}, hi, e.hi);
        chk({e.nm, "_lo"}, lo, e.lo);
      end
    end
  end

  // Issuing while busy must never happen.
  always @(posedge clk) begin
    if (rst_n && start && busy) begin
      fails++;
      $display("FAIL start_while_busy: start=1 busy=1 required busy=0");
    end
  end

  function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0;
    case (o)
      MD_MULT:  r = 64'(sa * sb);
      MD_MULTU: r = {32'b0, a} * {32'b0, b};
      MD_DIV:   r = (b == 0) ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
      MD_DIVU:  r = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      default:  r = '0;
    endcase
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] eh, input logic [31:0] el, input string nm);
    exp_t e;
    op = o; rs = a; rt = b; start = 1'b1;
    if (push) begin
      e.hi = eh; e.lo = el; e.nm = nm;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int busy_cycles);
    busy_cycles = 0;
    for (int g = 0; g < 60 && !done; g++) begin
      if (busy) busy_cycles++;
      @(negedge clk);
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: done=0 after 60 cycles, required done=1", nm);
    end
  endtask

  task automatic run(input vec_t v);
    int bc;
    issue(v.op, v.a, v.b, 1'b1, v.eh, v.el, v.nm);
    wait_done(v.nm, bc);
    chk({v.nm, "_busy_cycles"}, 32'(bc), 32'd33);
    chk({v.nm, "_busy_at_done"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[11];
    vec_t v;
    int bc;
    logic [63:0] m;

    vecs[0]  = '{MD_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, "mult_neg1x2"};
    vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, "multu_ffx2"};
    vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2"};
    vecs[3]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"};
    vecs[4]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7_m2"};
    vecs[5]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_min_min"};
    vecs[6]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
    vecs[7]  = '{MD_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, "divu_100_7"};
    vecs[8]  = '{MD_DIV,   32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, "div_5_0"};
    vecs[9]  = '{MD_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, "div_m5_0"};
    vecs[10] = '{MD_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, "divu_by0"};

    // Reset values
    #3;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run(vecs[i]);

    // MTLO right after the divide-by-zero result
    issue(MD_MTLO, 32'hA5A5A5A5, 32'h0, 1'b0, '0, '0, "");
    chk("mtlo_lo", lo, 32'hA5A5A5A5);
    chk("mtlo_hi_kept", hi, 32'h12345678);
    chk("mtlo_busy", {31'b0, busy}, 32'd0);
    chk("mtlo_done", {31'b0, done}, 32'd0);
    issue(MD_MTHI, 32'h0BADF00D, 32'h0, 1'b0, '0, '0, "");
    chk("mthi_hi", hi, 32'h0BADF00D);

    // Undefined op: nothing changes
    issue(3'b110, 32'h11111111, 32'h0, 1'b0, '0, '0, "");
    chk("undef_hi", hi, 32'h0BADF00D);
    chk("undef_lo", lo, 32'hA5A5A5A5);
    chk("undef_busy", {31'b0, busy}, 32'd0);

    // Back-to-back: second issue on the done cycle
    issue(MD_MULTU, 32'h00010000, 32'h00010000, 1'b1, 32'h00000001, 32'h00000000, "b2b_first");
    wait_done("b2b_first", bc);
    issue(MD_DIVU, 32'hFFFFFFFF, 32'h0000000A, 1'b1, 32'h00000005, 32'h19999999, "b2b_second");
    wait_done("b2b_second", bc);
    chk("b2b_second_busy_cycles", 32'(bc), 32'd33);

    // Random pairs against the reference model
    for (int i = 0; i < 8; i++) begin
      v.op = 3'($urandom_range(0, 3));
      v.a  = $urandom;
      v.b  = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      if (i % 2 == 1) v.b = -v.b;
      m    = ref_md(v.op, v.a, v.b);
      v.eh = m[63:32];
      v.el = m[31:0];
      v.nm = $sformatf("rand%0d_op%0d", i, v.op);
      run(v);
    end

    // Flush mid-run: HI/LO keep their pre-issue values, no done
    issue(MD_MTHI, 32'h00000001, 32'h0, 1'b0, '0, '0, "");
    issue(MD_MTLO, 32'h00000002, 32'h0, 1'b0, '0, '0, "");
    issue(MD_MULT, 32'h00000003, 32'h00000004, 1'b0, '0, '0, "");
    repeat (8) @(negedge clk);
    chk("flush_busy_before", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_hi", hi, 32'h1);
    chk("flush_lo", lo, 32'h2);
    repeat (40) @(negedge clk);
    chk("flush_hi_later", hi, 32'h1);
    chk("flush_lo_later", lo, 32'h2);

    // Flush together with start in IDLE drops the op
    flush = 1'b1;
    issue(MD_MTHI, 32'hDEADBEEF, 32'h0, 1'b0, '0, '0, "");
    flush = 1'b0;
    chk("flush_idle_hi", hi, 32'h1);
    chk("flush_idle_busy", {31'b0, busy}, 32'd0);

    // Async reset mid-run
    issue(MD_MULT, 32'h00000005, 32'h00000006, 1'b0, '0, '0, "");
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("arst_lo_later", lo, 32'h0);

    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d results pending, required 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
